// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The control bundle groups the five pipeline steering signals so each case is a single constant.
package hazard_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_flush;
      logic pipe_hold;
   } ctrl_t;

   localparam ctrl_t CTRL_RUN = '{
      pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0, pipe_hold: 1'b0
   };

   localparam ctrl_t CTRL_RESET = '{
      pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1, id_ex_flush: 1'b1, pipe_hold: 1'b0
   };

   localparam ctrl_t CTRL_HOLD = '{
      pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b0, pipe_hold: 1'b1
   };

   localparam ctrl_t CTRL_REDIRECT = '{
      pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1, pipe_hold: 1'b0
   };

   // Bubble into EX while PC and IF/ID hold the dependent instruction for one cycle.
   localparam ctrl_t CTRL_LOAD_USE = '{
      pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b1, pipe_hold: 1'b0
   };

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
// Purely combinational, zero latency; x0 is never a dependency.
module load_use_detect
   import hazard_pkg::*;
(
   input  logic [4:0] id_src1_addr,
   input  logic [4:0] id_src2_addr,
   input  logic       id_uses_src1,
   input  logic       id_uses_src2,
   input  logic [4:0] id_ex_dest_addr,
   input  logic       id_ex_mem_read,
   output logic       load_use_hazard
);

   logic src1_match;
   logic src2_match;

   assign src1_match = id_uses_src1 && (id_src1_addr == id_ex_dest_addr);
   assign src2_match = id_uses_src2 && (id_src2_addr == id_ex_dest_addr);

   assign load_use_hazard = id_ex_mem_read
                          && (id_ex_dest_addr != REG_ZERO)
                          && (src1_match || src2_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencing for the 5-stage pipeline: load-use, EX redirects and data-memory waits.
// Controls are Mealy (same cycle as inputs); memory waits freeze the whole pipe until ready or timeout.
module pipeline_hazard_controller
   import hazard_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64,
   parameter int TMO_W       = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_src1_addr,
   input  logic [4:0]       id_src2_addr,
   input  logic             id_uses_src1,
   input  logic             id_uses_src2,
   input  logic [4:0]       id_ex_dest_addr,
   input  logic             id_ex_mem_read,
   input  logic             ex_redirect,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             pipe_hold,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam bit              TMO_EN   = (MEM_TIMEOUT != 0);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t           state;
   state_t           state_nxt;
   logic [TMO_W-1:0] wait_cnt;
   logic [TMO_W-1:0] wait_cnt_nxt;
   ctrl_t            ctrl;
   logic             mem_err_c;
   logic             redirect_taken;
   logic             load_use_hazard;

   load_use_detect u_load_use_detect (
      .id_src1_addr    (id_src1_addr),
      .id_src2_addr    (id_src2_addr),
      .id_uses_src1    (id_uses_src1),
      .id_uses_src2    (id_uses_src2),
      .id_ex_dest_addr (id_ex_dest_addr),
      .id_ex_mem_read  (id_ex_mem_read),
      .load_use_hazard (load_use_hazard)
   );

   always_comb begin
      ctrl           = CTRL_RUN;
      state_nxt      = state;
      wait_cnt_nxt   = wait_cnt;
      mem_err_c      = 1'b0;
      redirect_taken = 1'b0;
      if (rst) begin
         ctrl = CTRL_RESET;
      end else begin
         case (state)
            RUN: begin
               // A stalled memory access freezes EX, so a redirect or load-use there is seen again later.
               if (mem_req && !mem_ready) begin
                  ctrl         = CTRL_HOLD;
                  state_nxt    = MEM_WAIT;
                  wait_cnt_nxt = TMO_W'(1);
               end else if (ex_redirect) begin
                  ctrl           = CTRL_REDIRECT;
                  redirect_taken = 1'b1;
               end else if (load_use_hazard) begin
                  ctrl = CTRL_LOAD_USE;
               end
            end
            MEM_WAIT: begin
               ctrl = CTRL_HOLD;
               if (mem_ready) begin
                  state_nxt    = RUN;
                  wait_cnt_nxt = '0;
               end else if (TMO_EN && (wait_cnt == TMO_LAST)) begin
                  // Access is abandoned; recovery belongs to the trap path.
                  mem_err_c    = 1'b1;
                  state_nxt    = RUN;
                  wait_cnt_nxt = '0;
               end else begin
                  wait_cnt_nxt = wait_cnt + 1'b1;
               end
            end
            default: begin
               state_nxt    = RUN;
               wait_cnt_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         wait_cnt    <= '0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (!ctrl.pc_write && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
         end
         if (redirect_taken && (flush_count != '1)) begin
            flush_count <= flush_count + 1'b1;
         end
      end
   end

   assign pc_write    = ctrl.pc_write;
   assign if_id_write = ctrl.if_id_write;
   assign if_id_flush = ctrl.if_id_flush;
   assign id_ex_flush = ctrl.id_ex_flush;
   assign pipe_hold   = ctrl.pipe_hold;
   assign mem_error   = mem_err_c;

endmodule
